// File: rtl/vend_sequencer.sv
// vend_sequencer: vending transaction controller. Accumulates coin credit,
// checks a selection against its price, runs the dispenser req/ack handshake
// and pays out change as 5-jiao pulses spaced CHG_GAP cycles apart.
// Optional feature macro: VEND_AUTO_REFUND_EN (refund after IDLE_TIMEOUT
// quiet cycles while holding credit).
module vend_sequencer #(
   parameter int PRICE0       = 25,
   parameter int PRICE1       = 30,
   parameter int PRICE2       = 15,
   parameter int PRICE3       = 50,
   parameter int MAX_CREDIT   = 95,
   parameter int CHG_GAP      = 50_000_000,
   parameter int IDLE_TIMEOUT = 1_500_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin5,
   input  logic       coin10,
   input  logic       sel_valid,
   input  logic [1:0] sel_id,
   input  logic       cancel,
   input  logic       disp_ack,
   output logic       disp_req,
   output logic [1:0] disp_id,
   output logic       chg_pulse,
   output logic       coin_reject,
   output logic       no_funds,
   output logic       vend_ok,
   output logic [7:0] credit,
   output logic       busy
);

   // Reject nonsensical parameter sets at elaboration.
   if (CHG_GAP < 2 || IDLE_TIMEOUT < 2 || MAX_CREDIT > 255 || (MAX_CREDIT % 5) != 0 ||
       (PRICE0 % 5) != 0 || (PRICE1 % 5) != 0 || (PRICE2 % 5) != 0 || (PRICE3 % 5) != 0 ||
       PRICE0 > MAX_CREDIT || PRICE1 > MAX_CREDIT || PRICE2 > MAX_CREDIT ||
       PRICE3 > MAX_CREDIT) begin : g_param_check
      $error("vend_sequencer: illegal parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_DISPENSE, S_CHANGE} state_t;

   localparam logic [7:0]  P0       = 8'(PRICE0);
   localparam logic [7:0]  P1       = 8'(PRICE1);
   localparam logic [7:0]  P2       = 8'(PRICE2);
   localparam logic [7:0]  P3       = 8'(PRICE3);
   localparam logic [8:0]  MAX9     = 9'(MAX_CREDIT);
   localparam logic [31:0] CHG_LAST = 32'(CHG_GAP - 1);

   state_t      state, state_nxt;
   logic [7:0]  credit_nxt;
   logic [1:0]  disp_id_nxt;
   logic        disp_req_nxt, chg_nxt, rej_nxt, nf_nxt, ok_nxt, busy_nxt;
   logic [31:0] gap_cnt, gap_nxt;
   logic [7:0]  price;
   logic [8:0]  sum;
   logic        coin_any;

`ifdef VEND_AUTO_REFUND_EN
   localparam logic [31:0] IDLE_LAST = 32'(IDLE_TIMEOUT - 1);
   logic [31:0] idle_cnt, idle_nxt;
`endif

   // Credit after this cycle's coins, one bit wider so overflow is visible.
   assign coin_any = coin5 | coin10;
   assign sum      = {1'b0, credit} + (coin5 ? 9'd5 : 9'd0) + (coin10 ? 9'd10 : 9'd0);

   // Price lookup for the requested product.
   always_comb begin
      price = P0;
      case (sel_id)
         2'd0:    price = P0;
         2'd1:    price = P1;
         2'd2:    price = P2;
         default: price = P3;
      endcase
   end

   // Next-state and next-output decode; pulses default low every cycle.
   always_comb begin
      state_nxt    = state;
      credit_nxt   = credit;
      disp_id_nxt  = disp_id;
      disp_req_nxt = disp_req;
      chg_nxt      = 1'b0;
      rej_nxt      = 1'b0;
      nf_nxt       = 1'b0;
      ok_nxt       = 1'b0;
      gap_nxt      = gap_cnt;
`ifdef VEND_AUTO_REFUND_EN
      idle_nxt     = '0;
`endif
      case (state)
         S_IDLE, S_CREDIT: begin
            // cancel beats selection beats coins; coins lose to either
            if (cancel) begin
               rej_nxt = coin_any;
               if (state == S_CREDIT) begin
                  state_nxt = S_CHANGE;
                  gap_nxt   = '0;
               end
            end else if (sel_valid) begin
               rej_nxt = coin_any;
               if (state == S_CREDIT && credit >= price) begin
                  credit_nxt   = credit - price;
                  disp_id_nxt  = sel_id;
                  disp_req_nxt = 1'b1;
                  state_nxt    = S_DISPENSE;
               end else begin
                  nf_nxt = 1'b1;
               end
            end else if (coin_any) begin
               if (sum <= MAX9) begin
                  credit_nxt = sum[7:0];
                  state_nxt  = S_CREDIT;
               end else begin
                  rej_nxt = 1'b1;
               end
            end
`ifdef VEND_AUTO_REFUND_EN
            else if (state == S_CREDIT) begin
               if (idle_cnt == IDLE_LAST) begin
                  state_nxt = S_CHANGE;
                  gap_nxt   = '0;
               end else begin
                  idle_nxt = idle_cnt + 32'd1;
               end
            end
`endif
         end
         S_DISPENSE: begin
            rej_nxt = coin_any;
            if (disp_ack) begin
               disp_req_nxt = 1'b0;
               ok_nxt       = 1'b1;
               gap_nxt      = '0;
               state_nxt    = (credit != 8'd0) ? S_CHANGE : S_IDLE;
            end
         end
         default: begin // S_CHANGE
            rej_nxt = coin_any;
            if (gap_cnt == CHG_LAST) begin
               chg_nxt    = 1'b1;
               credit_nxt = credit - 8'd5;
               gap_nxt    = '0;
               if (credit == 8'd5) state_nxt = S_IDLE;
            end else begin
               gap_nxt = gap_cnt + 32'd1;
            end
         end
      endcase
      busy_nxt = (state_nxt == S_DISPENSE) || (state_nxt == S_CHANGE);
   end

   // State and registered outputs; reset discards any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         credit      <= '0;
         disp_id     <= '0;
         disp_req    <= 1'b0;
         chg_pulse   <= 1'b0;
         coin_reject <= 1'b0;
         no_funds    <= 1'b0;
         vend_ok     <= 1'b0;
         busy        <= 1'b0;
         gap_cnt     <= '0;
      end else begin
         state       <= state_nxt;
         credit      <= credit_nxt;
         disp_id     <= disp_id_nxt;
         disp_req    <= disp_req_nxt;
         chg_pulse   <= chg_nxt;
         coin_reject <= rej_nxt;
         no_funds    <= nf_nxt;
         vend_ok     <= ok_nxt;
         busy        <= busy_nxt;
         gap_cnt     <= gap_nxt;
      end
   end

`ifdef VEND_AUTO_REFUND_EN
   // Inactivity counter; only advances while holding credit.
   always_ff @(posedge clk) begin
      if (rst) idle_cnt <= '0;
      else     idle_cnt <= idle_nxt;
   end
`endif

endmodule
